// File: rtl/riscv_pkg.sv
// Shared register-file types for the writeback path: register address, busy mask,
// writeback request record and the arbitration pointer encoding.
package riscv_pkg;

   localparam int unsigned NUM_REGS  = 32;
   localparam int unsigned WB_DATA_W = 64;

   localparam int unsigned REQ_LOAD = 0;
   localparam int unsigned REQ_ALU  = 1;

   typedef logic [4:0]          reg_addr_t;
   typedef logic [NUM_REGS-1:0] reg_mask_t;

   typedef struct packed {
      logic                 valid;
      reg_addr_t            rd;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic {
      PTR_LOAD = 1'b0,
      PTR_ALU  = 1'b1
   } arb_ptr_t;

   function automatic reg_mask_t reg_onehot(input reg_addr_t r);
      reg_onehot    = '0;
      reg_onehot[r] = 1'b1;
   endfunction

endpackage

// File: rtl/riscv_wb_arbiter.sv
// Two-requester writeback arbiter (load, ALU); fixed load-first priority by default,
// round-robin with a 1-bit pointer when RISCV_WB_ROUND_ROBIN_EN is defined.
module riscv_wb_arbiter
   import riscv_pkg::*;
(
`ifdef RISCV_WB_ROUND_ROBIN_EN
   input  logic       clock,
`endif
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant
);

`ifdef RISCV_WB_ROUND_ROBIN_EN
   arb_ptr_t ptr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         ptr <= PTR_LOAD;
      else if (|grant)
         ptr <= grant[REQ_LOAD] ? PTR_ALU : PTR_LOAD;
   end

   always_comb begin
      grant = '0;
      if (!reset) begin
         if (req[REQ_LOAD] && (ptr == PTR_LOAD || !req[REQ_ALU]))
            grant[REQ_LOAD] = 1'b1;
         else if (req[REQ_ALU])
            grant[REQ_ALU] = 1'b1;
      end
   end
`else
   always_comb begin
      grant = '0;
      if (!reset) begin
         if (req[REQ_LOAD])
            grant[REQ_LOAD] = 1'b1;
         else if (req[REQ_ALU])
            grant[REQ_ALU] = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/riscv_writeback_scheduler.sv
// Writeback scheduler: busy scoreboard with issue stall, load/ALU arbitration and a
// registered register-file write port. RISCV_WB_ROUND_ROBIN_EN selects round-robin.
module riscv_writeback_scheduler
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                issue_valid,
   input  logic [4:0]          issue_rd,
   input  logic [4:0]          rs1_addr,
   input  logic [4:0]          rs2_addr,
   output logic                stall,
   input  logic                alu_valid,
   input  logic [4:0]          alu_rd,
   input  logic [XLEN-1:0]     alu_data,
   output logic                alu_ready,
   input  logic                load_valid,
   input  logic [4:0]          load_rd,
   input  logic [XLEN-1:0]     load_data,
   output logic                load_ready,
   output logic                rd_enable_write,
   output logic [4:0]          rd_addr,
   output logic [XLEN-1:0]     rd_data,
   output logic [NUM_REGS-1:0] busy
);

   logic [1:0] grant;
   logic       xfer;
   wb_req_t    alu_req;
   wb_req_t    load_req;
   wb_req_t    sel;
   reg_mask_t  set_mask;
   reg_mask_t  clr_mask;
   logic       unused_sel;

   riscv_wb_arbiter u_arb (
`ifdef RISCV_WB_ROUND_ROBIN_EN
      .clock (clock),
`endif
      .reset (reset),
      .req   ({alu_valid, load_valid}),
      .grant (grant)
   );

   always_comb begin
      alu_req  = '{valid: alu_valid,  rd: alu_rd,  data: WB_DATA_W'(alu_data)};
      load_req = '{valid: load_valid, rd: load_rd, data: WB_DATA_W'(load_data)};
      sel      = grant[REQ_LOAD] ? load_req : alu_req;
   end

   assign alu_ready  = grant[REQ_ALU];
   assign load_ready = grant[REQ_LOAD];
   assign xfer       = |grant;
   assign unused_sel = ^{sel.valid, sel.data};

   // busy[0] is never set, so x0 can never stall issue.
   assign stall = issue_valid & (busy[rs1_addr] | busy[rs2_addr] | busy[issue_rd]);

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_valid && !stall && issue_rd != '0)
         set_mask = reg_onehot(issue_rd);
      if (rd_enable_write)
         clr_mask = reg_onehot(rd_addr);
   end

   // Set is ORed in after the clear so a same-edge issue to the retiring register wins.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         busy <= '0;
      else
         busy <= (busy & ~clr_mask) | set_mask;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_enable_write <= 1'b0;
         rd_addr         <= '0;
         rd_data         <= '0;
      end else begin
         rd_enable_write <= xfer && (sel.rd != '0);
         if (xfer && sel.rd != '0) begin
            rd_addr <= sel.rd;
            rd_data <= sel.data[XLEN-1:0];
         end
      end
   end

endmodule
